sram_1rw_req_resp: RTL and testbench
====================================

// Module: sram_1rw_req_resp
// PURPOSE
//  Parametrised single-port (1RW) SRAM with valid/ready request and response channels.
//  Adds byte-masked writes, a configurable read latency and a backpressure-safe response buffer.
//  Adds an optional zero-initialisation sweep after reset.
//  Used in front of cache tag/data arrays and predictor tables in place of fixed-size 1RW wrappers.
// PARAMETERS
//  DATA_W      64   data width in bits; must be a multiple of 8
//  DEPTH       64   number of words; power of 2, >= 2
//  LATENCY     1    read latency: request accept edge to response-buffer write edge; 1 or 2
//  RESP_DEPTH  3    response buffer entries; full throughput requires >= LATENCY+2
//  ZERO_INIT   1    1 = clear all words after reset; 0 = contents undefined after reset
// PORTS
//  clk         in   1              clock; all logic on the rising edge
//  rst         in   1              reset, asynchronous, active-high
//  req_valid   in   1              request present
//  req_ready   out  1              request accepted when req_valid && req_ready
//  req_write   in   1              1 = write, 0 = read
//  req_addr    in   log2(DEPTH)    word address
//  req_wdata   in   DATA_W         write data
//  req_wmask   in   DATA_W/8       byte write enables; bit i covers wdata[8i+7:8i]
//  resp_valid  out  1              read data present
//  resp_ready  in   1              response consumed when resp_valid && resp_ready
//  resp_data   out  DATA_W         read data, in request order
//  init_done   out  1              high once the array is usable
// BEHAVIOUR
//  - Reset (async, rst=1): req_ready=0, resp_valid=0, resp_data=0, init_done=0.
//    Reset also sets state=INIT, init_addr=0, pending=0 and buffer empty. Array contents are not reset.
//  - FSM INIT -> RUN:
//    - ZERO_INIT=1: INIT writes all-zero to init_addr 0..DEPTH-1, one word per cycle (DEPTH cycles).
//      RUN is entered on the edge that writes word DEPTH-1.
//    - ZERO_INIT=0: INIT lasts exactly one cycle.
//    - init_done = (state==RUN). No path leads back to INIT except rst.
//  - Occupancy = pending reads (accepted, not yet in the buffer) + buffer count.
//    Counter width is clog2(RESP_DEPTH+1).
//  - req_ready = (state==RUN) && (occupancy < RESP_DEPTH).
//    req_ready is registered-state only; there is no combinational path from req_valid, req_write or resp_ready to req_ready.
//  - Writes and reads are gated identically. A write produces no response.
//  - Write accepted at edge E: bytes with wmask=1 updated at E; unmasked bytes keep their value. wmask=0 is a legal no-op.
//  - Read accepted at edge E0:
//    - Data is written into the buffer at edge E_LATENCY.
//    - resp_valid is high in the cycle after that edge at the earliest.
//    - Read data reflects all writes accepted before E0.
//  - Read-after-write to the same address on consecutive cycles returns the new data (single port, so there is no hazard).
//  - Buffer is a FIFO:
//    - resp_data/resp_valid are driven from the head register.
//    - resp_data holds its value while resp_valid && !resp_ready.
//    - resp_data may hold stale data while resp_valid=0.
//  - Simultaneous push and pop: occupancy changes by (accept_read - pop). Push into a full buffer is impossible by construction.
//  - rst mid-operation: pending reads and buffered responses are dropped without a response.
//    An in-progress write completes or is lost as a whole word's masked bytes. INIT restarts from address 0.
//  - X on req_* while req_valid=0 must not affect state.
// TESTING
//  1 ZERO_INIT=1, DEPTH=64: release rst -> init_done rises exactly 64 cycles later; read addr 5 -> resp_data=0.
//  2 Write addr 3 data 64'h1122334455667788 mask 8'hFF, then data 64'hAAAAAAAAAAAAAAAA mask 8'h0F, then read 3
//    -> resp_data=64'h11223344AAAAAAAA, resp_valid one cycle after the buffer-write edge (LATENCY=1).
//  3 resp_ready=0, 5 back-to-back reads of addrs 0..4 -> exactly 3 accepted, req_ready low until a pop.
//    Then raise resp_ready -> data of addrs 0,1,2 returned in order, then 3,4 accepted.
//  4 LATENCY=2, RESP_DEPTH=4, resp_ready=1, 100 back-to-back reads
//    -> after the first, req_ready stays high, one response per cycle, order preserved.
//  5 Write addr 7 at cycle N and read addr 7 at cycle N+1 -> new data returned;
//    write with wmask=0 leaves word unchanged.
//  6 Assert rst while 2 reads are buffered and 1 is pending -> resp_valid=0 immediately (async).
//    No stale response after release; INIT sweep reruns.

Source files
------------

// File: rtl/sram_1rw_req_resp.sv
// Single-port SRAM with valid/ready request and response channels, byte-masked writes,
// 1- or 2-cycle read latency, a response FIFO sized by occupancy, and an optional zero sweep after reset.
module sram_1rw_req_resp #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned RESP_DEPTH = 3,
    parameter int unsigned ZERO_INIT  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [$clog2(DEPTH)-1:0]   req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_wmask,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_data,
    output logic                       init_done
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned OCC_W  = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [OCC_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]   head_d;
    logic                init_we;
    logic                accept;
    logic                accept_rd;
    logic                accept_wr;
    logic                pop;
    logic                push;

    logic                pipe_valid_q [LATENCY];
    logic [DATA_W-1:0]   pipe_data_q  [LATENCY];
    logic [DATA_W-1:0]   fifo_mem     [RESP_DEPTH];
    logic [DATA_W-1:0]   mem          [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state, handshake decode and response-head selection
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        occ_d       = occ_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        head_d      = resp_data;
        init_we     = 1'b0;
        accept      = req_valid && req_ready;
        accept_rd   = accept && !req_write;
        accept_wr   = accept && req_write;
        pop         = resp_valid && resp_ready;
        push        = pipe_valid_q[LATENCY-1];

        unique case (state_q)
            ST_INIT: begin
                if (ZERO_INIT != 0) begin
                    init_we     = 1'b1;
                    init_addr_d = init_addr_q + ADDR_W'(1);
                    if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Occupancy reserves a buffer slot from accept until pop, so a push never finds the FIFO full
        occ_d = occ_q + OCC_W'(accept_rd) - OCC_W'(pop);
        cnt_d = cnt_q + OCC_W'(push) - OCC_W'(pop);
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (cnt_d != '0) begin
            if ((cnt_q - OCC_W'(pop)) == '0) begin
                head_d = pipe_data_q[LATENCY-1];
            end else begin
                head_d = fifo_mem[rd_ptr_d];
            end
        end
    end

    // FSM state and sweep address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // Occupancy, FIFO pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            init_done  <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            req_ready  <= (state_d == ST_RUN) && (occ_d < OCC_W'(RESP_DEPTH));
            resp_valid <= (cnt_d != '0);
            resp_data  <= head_d;
            init_done  <= (state_d == ST_RUN);
        end
    end

    // Read pipeline occupancy flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid_q[i] <= 1'b0;
            end
        end else begin
            pipe_valid_q[0] <= accept_rd;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
            end
        end
    end

    // Read data pipeline and FIFO storage (no reset needed)
    always_ff @(posedge clk) begin
        if (accept_rd) begin
            pipe_data_q[0] <= mem[req_addr];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
        if (push) begin
            fifo_mem[wr_ptr_q] <= pipe_data_q[LATENCY-1];
        end
    end

    // Array write port: zero sweep during INIT, masked writes afterwards
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr_q] <= '0;
        end else if (accept_wr) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (req_wmask[b]) begin
                    mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw_req_resp.sv
// Bench for sram_1rw_req_resp: two instances (LATENCY=1/RESP_DEPTH=3 and LATENCY=2/RESP_DEPTH=4)
// checked every cycle against a transaction-level memory/response-queue model plus directed steps.
module tb_sram_1rw_req_resp;

    localparam int NDUT = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic        req_write  [NDUT];
    logic [5:0]  req_addr   [NDUT];
    logic [63:0] req_wdata  [NDUT];
    logic [7:0]  req_wmask  [NDUT];
    logic        resp_valid [NDUT];
    logic        resp_ready [NDUT];
    logic [63:0] resp_data  [NDUT];
    logic        init_done  [NDUT];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int since_rel = 0;
    int outstanding [NDUT];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) since_rel <= 0;
        else     since_rel <= since_rel + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        localparam int LAT = (d == 0) ? 1 : 2;
        localparam int RD  = (d == 0) ? 3 : 4;

        sram_1rw_req_resp #(
            .DATA_W(64), .DEPTH(DEPTH), .LATENCY(LAT), .RESP_DEPTH(RD), .ZERO_INIT(1)
        ) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[d]), .req_ready(req_ready[d]), .req_write(req_write[d]),
            .req_addr(req_addr[d]), .req_wdata(req_wdata[d]), .req_wmask(req_wmask[d]),
            .resp_valid(resp_valid[d]), .resp_ready(resp_ready[d]), .resp_data(resp_data[d]),
            .init_done(init_done[d])
        );

        // Model: memory image plus queue of accepted reads with the cycle their data becomes visible
        logic [63:0] mdl [DEPTH];
        logic [63:0] qd [$];
        int          qr [$];

        always @(negedge clk) begin
            if (rst) begin
                check("rst_req_ready", 64'(req_ready[d]), 64'd0);
                check("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
                check("rst_init_done", 64'(init_done[d]), 64'd0);
                check("rst_resp_data", resp_data[d], 64'd0);
                qd.delete();
                qr.delete();
                foreach (mdl[i]) mdl[i] = 64'd0;
            end else begin
                check("init_done", 64'(init_done[d]), 64'(since_rel >= DEPTH));
                check("req_ready", 64'(req_ready[d]), 64'((since_rel >= DEPTH) && (qd.size() < RD)));
                check("resp_valid", 64'(resp_valid[d]), 64'((qd.size() > 0) && (cyc >= qr[0])));
                if ((qd.size() > 0) && (cyc >= qr[0])) begin
                    check("resp_data", resp_data[d], qd[0]);
                end
                if (resp_valid[d] && resp_ready[d] && (qd.size() > 0)) begin
                    void'(qd.pop_front());
                    void'(qr.pop_front());
                end
                if (req_valid[d] && req_ready[d]) begin
                    if (req_write[d]) begin
                        for (int b = 0; b < 8; b++) begin
                            if (req_wmask[d][b]) mdl[req_addr[d]][8*b +: 8] = req_wdata[d][8*b +: 8];
                        end
                    end else begin
                        qd.push_back(mdl[req_addr[d]]);
                        qr.push_back(cyc + 1 + LAT);
                    end
                end
            end
            outstanding[d] = qd.size();
        end
    end

    task automatic idle(input int d);
        req_valid[d] = 1'b0;
        req_write[d] = 1'bx;
        req_addr[d]  = 'x;
        req_wdata[d] = 'x;
        req_wmask[d] = 'x;
    endtask

    // Present one request from a posedge+1 slot until accepted; returns at accept edge + 1
    task automatic issue(input int d, input bit wr, input logic [5:0] addr,
                         input logic [63:0] data, input logic [7:0] mask);
        bit ok;
        ok = 1'b0;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = data;
        req_wmask[d] = mask;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready[d];
            @(posedge clk);
            #1;
        end
        idle(d);
        check("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic get_resp(input int d, output logic [63:0] data);
        bit got;
        got = 1'b0;
        data = '0;
        resp_ready[d] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (resp_valid[d]) begin
                got = 1'b1;
                data = resp_data[d];
            end
            @(posedge clk);
            #1;
        end
        check("resp_timeout", 64'(got), 64'd1);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        resp_ready[d] = 1'b1;
        while (outstanding[d] != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(outstanding[d]), 64'd0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done[0] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(n), 64'd64);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [63:0] wd;
        int acc, stalls, rcnt, first, last;

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            idle(d);
            resp_ready[d] = 1'b1;
            outstanding[d] = 0;
        end

        // Reset and zero sweep timing
        repeat (3) @(posedge clk);
        #1;
        check("t1_rst_ready", 64'(req_ready[0]), 64'd0);
        rst = 1'b0;
        wait_init("t1_init_cycles");
        issue(0, 1'b0, 6'd5, '0, '0);
        get_resp(0, r);
        check("t1_read5_zero", r, 64'd0);

        // Masked write merge and LATENCY=1 response timing
        issue(0, 1'b1, 6'd3, 64'h1122334455667788, 8'hFF);
        issue(0, 1'b1, 6'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        issue(0, 1'b0, 6'd3, '0, '0);
        @(negedge clk);
        check("t2_valid_early", 64'(resp_valid[0]), 64'd0);
        @(negedge clk);
        check("t2_valid", 64'(resp_valid[0]), 64'd1);
        check("t2_data", resp_data[0], 64'h11223344AAAAAAAA);
        @(posedge clk);
        #1;

        // Backpressure: only RESP_DEPTH reads accepted while responses are blocked
        for (int a = 0; a < 5; a++) issue(0, 1'b1, 6'(a), {$urandom, $urandom}, 8'hFF);
        resp_ready[0] = 1'b0;
        acc = 0;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 6'd0;
        for (int i = 0; i < 30 && acc < 5; i++) begin
            if (i == 8) begin
                check("t3_accepted", 64'(acc), 64'd3);
                check("t3_ready_low", 64'(req_ready[0]), 64'd0);
                resp_ready[0] = 1'b1;
            end
            @(negedge clk);
            if (req_ready[0]) acc++;
            @(posedge clk);
            #1;
            req_addr[0] = 6'(acc);
        end
        idle(0);
        check("t3_all_accepted", 64'(acc), 64'd5);
        drain(0);

        // LATENCY=2 full throughput
        for (int a = 0; a < 16; a++) issue(1, 1'b1, 6'(a), {$urandom, $urandom}, 8'($urandom));
        resp_ready[1] = 1'b1;
        acc = 0; stalls = 0; rcnt = 0; first = -1; last = -1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 6'($urandom_range(0, 15));
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            if (resp_valid[1]) begin
                rcnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (req_valid[1]) begin
                if (req_ready[1]) acc++;
                else if (acc > 0) stalls++;
            end
            @(posedge clk);
            #1;
            if (acc < 100) req_addr[1] = 6'($urandom_range(0, 15));
            else idle(1);
        end
        check("t4_accepted", 64'(acc), 64'd100);
        check("t4_stalls", 64'(stalls), 64'd0);
        check("t4_responses", 64'(rcnt), 64'd100);
        check("t4_span", 64'(last - first), 64'd99);

        // Read-after-write and no-op mask
        wd = {$urandom, $urandom};
        issue(0, 1'b1, 6'd7, wd, 8'hFF);
        issue(0, 1'b0, 6'd7, '0, '0);
        get_resp(0, r);
        check("t5_raw", r, wd);
        issue(0, 1'b1, 6'd7, ~wd, 8'h00);
        issue(0, 1'b0, 6'd7, '0, '0);
        get_resp(0, r);
        check("t5_mask0", r, wd);

        // Random mixed traffic on both instances
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < NDUT; d++) begin
                req_valid[d]  = ($urandom_range(0, 2) != 0);
                req_write[d]  = ($urandom_range(0, 2) == 0);
                req_addr[d]   = 6'($urandom_range(0, 7));
                req_wdata[d]  = {$urandom, $urandom};
                req_wmask[d]  = 8'($urandom);
                resp_ready[d] = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk);
            #1;
        end
        for (int d = 0; d < NDUT; d++) begin
            idle(d);
            drain(d);
        end

        // Reset with two buffered and one pending read
        resp_ready[0] = 1'b0;
        for (int a = 0; a < 3; a++) issue(0, 1'b0, 6'(a), '0, '0);
        check("t6_valid_before", 64'(resp_valid[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_async_valid", 64'(resp_valid[0]), 64'd0);
        check("t6_async_ready", 64'(req_ready[0]), 64'd0);
        check("t6_async_done", 64'(init_done[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resp_ready[0] = 1'b1;
        wait_init("t6_init_cycles");
        issue(0, 1'b0, 6'd3, '0, '0);
        get_resp(0, r);
        check("t6_swept", r, 64'd0);
        drain(0);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
